// File: rtl/seq_trace_capture.sv
// rtl/seq_trace_capture.sv - change-triggered, timestamped trace capture of three result buses into a ready/valid FIFO
module seq_trace_capture #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          a,
    input  logic [DATA_W-1:0]          b,
    input  logic [DATA_W-1:0]          c,
    input  logic                       cap_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [TS_W+3*DATA_W-1:0]   out_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int AW    = $clog2(DEPTH);
    localparam int REC_W = TS_W + 3*DATA_W;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [TS_W-1:0]   r_ts;
    logic              r_armed;
    logic [DATA_W-1:0] r_prev_a;
    logic [DATA_W-1:0] r_prev_b;
    logic [DATA_W-1:0] r_prev_c;

    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_overflow;
    logic [7:0]        r_drop_cnt;

    logic              w_event;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [REC_W-1:0]  w_record;

    // Event when capture is on and either this is the first enabled cycle or any bus moved
    always_comb begin
        w_event  = cap_en && (!r_armed || (a != r_prev_a) || (b != r_prev_b) || (c != r_prev_c));
        w_full   = (r_count == FULL_CNT);
        w_pop    = (r_count != '0) && out_ready;
        // A simultaneous pop frees the slot the new record needs
        w_push   = w_event && (!w_full || w_pop);
        w_drop   = w_event && w_full && !w_pop;
        w_record = {r_ts, c, b, a};
    end

    // Free-running timestamp and change-detection history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ts     <= '0;
            r_armed  <= 1'b0;
            r_prev_a <= '0;
            r_prev_b <= '0;
            r_prev_c <= '0;
        end else begin
            r_ts     <= r_ts + 1'b1;
            r_armed  <= cap_en;
            r_prev_a <= a;
            r_prev_b <= b;
            r_prev_c <= c;
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= w_record;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

    // Outputs come only from registers, so the buses never reach them combinationally
    always_comb begin
        out_valid = (r_count != '0);
        out_data  = r_mem[r_rptr];
        count     = r_count;
        overflow  = r_overflow;
        drop_cnt  = r_drop_cnt;
    end

endmodule
